// File: rtl/npu_fx_pkg.sv
// Fixed-point formats, saturation bounds and accumulator FSM states shared by
// the NPU post-processing stages.
package npu_fx_pkg;

    localparam int Q_FRAC_W = 16;
    localparam int IN_SUM_W = 38;
    localparam int BIAS_W   = 32;
    localparam int OUT_W    = 32;

    localparam logic [OUT_W-1:0] SAT_MAX_Q16_16 = 32'h7FFF_FFFF;
    localparam logic [OUT_W-1:0] SAT_MIN_Q16_16 = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_ACC  = 2'd0,
        ST_POST = 2'd1,
        ST_OUT  = 2'd2
    } accum_state_e;

endpackage

// File: rtl/sat_q16_16.sv
// Clamp a wide signed Q.16 value into the signed 32-bit Q16.16 range.
module sat_q16_16
    import npu_fx_pkg::*;
#(
    parameter int IN_W = 47
) (
    input  logic signed [IN_W-1:0]  din_i,
    output logic        [OUT_W-1:0] dout_o
);

    logic [IN_W-OUT_W:0] top_bits;
    logic                fits;

    // The value fits when every bit above bit 30 matches the sign.
    always_comb begin
        top_bits = din_i[IN_W-1:OUT_W-1];
        fits     = (top_bits == '0) || (top_bits == '1);
        if (fits) begin
            dout_o = din_i[OUT_W-1:0];
        end else if (din_i[IN_W-1]) begin
            dout_o = SAT_MIN_Q16_16;
        end else begin
            dout_o = SAT_MAX_Q16_16;
        end
    end

endmodule

// File: rtl/channel_accum_q16_16.sv
// Sums num_ch per-channel window sums, adds bias, optional ReLU, and emits one
// saturated Q16.16 pixel through a valid/ready output.
module channel_accum_q16_16
    import npu_fx_pkg::*;
#(
    parameter int ACC_W = 46,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [IN_SUM_W-1:0] in_sum,
    input  logic        [CNT_W-1:0]    num_ch,
    input  logic signed [BIAS_W-1:0]   bias,
    input  logic                       relu_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [OUT_W-1:0]    out_data
);

    accum_state_e             state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic        [CNT_W-1:0]  cnt_q, cnt_d;
    logic        [CNT_W-1:0]  nch_q, nch_d;
    logic signed [BIAS_W-1:0] bias_q, bias_d;
    logic                     relu_q, relu_d;
    logic        [OUT_W-1:0]  out_q, out_d;

    logic                     accept;
    logic                     first_beat;
    logic        [CNT_W-1:0]  cnt_inc;
    logic signed [ACC_W-1:0]  sum_ext;
    logic signed [ACC_W:0]    acc_ext;
    logic signed [ACC_W:0]    bias_ext;
    logic signed [ACC_W:0]    post_raw;
    logic signed [ACC_W:0]    post_relu;
    logic        [OUT_W-1:0]  post_sat;

    // Handshake outputs depend only on registered state.
    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_OUT);
    assign out_data  = out_q;

    assign accept     = in_valid && in_ready;
    assign first_beat = (cnt_q == '0);
    assign cnt_inc    = cnt_q + 1'b1;
    assign sum_ext    = {{(ACC_W-IN_SUM_W){in_sum[IN_SUM_W-1]}}, in_sum};

    assign acc_ext   = {acc_q[ACC_W-1], acc_q};
    assign bias_ext  = {{(ACC_W+1-BIAS_W){bias_q[BIAS_W-1]}}, bias_q};
    assign post_raw  = acc_ext + bias_ext;
    assign post_relu = (relu_q && post_raw[ACC_W]) ? '0 : post_raw;

    sat_q16_16 #(
        .IN_W (ACC_W + 1)
    ) u_sat (
        .din_i  (post_relu),
        .dout_o (post_sat)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        nch_d   = nch_q;
        bias_d  = bias_q;
        relu_d  = relu_q;
        out_d   = out_q;
        unique case (state_q)
            ST_ACC: begin
                if (accept) begin
                    if (first_beat) begin
                        nch_d  = num_ch;
                        bias_d = bias;
                        relu_d = relu_en;
                        acc_d  = sum_ext;
                        cnt_d  = CNT_W'(1);
                        if (num_ch <= CNT_W'(1)) begin
                            state_d = ST_POST;
                        end
                    end else begin
                        acc_d = acc_q + sum_ext;
                        cnt_d = cnt_inc;
                        if (cnt_inc == nch_q) begin
                            state_d = ST_POST;
                        end
                    end
                end
            end
            ST_POST: begin
                out_d   = post_sat;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    cnt_d   = '0;
                    state_d = ST_ACC;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_ACC;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            nch_q   <= '0;
            bias_q  <= '0;
            relu_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            nch_q   <= nch_d;
            bias_q  <= bias_d;
            relu_q  <= relu_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: tb/tb_channel_accum_q16_16.sv
// Self-checking bench for channel_accum_q16_16: vector table plus hand-written
// backpressure, reset and full-scale sequences, checked through a scoreboard.
module tb_channel_accum_q16_16;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [37:0] in_sum;
    logic        [7:0]  num_ch;
    logic signed [31:0] bias;
    logic               relu_en;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] out_data;

    channel_accum_q16_16 #(
        .ACC_W (46),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .num_ch    (num_ch),
        .bias      (bias),
        .relu_en   (relu_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic [31:0] sb[$];
    int          hs_cyc[$];
    logic [31:0] mon_exp;

    typedef struct {
        int              nbeats;
        logic [7:0]      nch;
        logic [31:0]     b;
        logic            relu;
        logic [3:0][37:0] sums;
        logic [31:0]     exp;
    } vec_t;

    vec_t vecs[9];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            hs_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out: got %h, expected no output", out_data);
            end else begin
                mon_exp = sb.pop_front();
                chk("out_data", out_data, mon_exp);
            end
        end
    end

    task automatic send_beat(input logic [37:0] s, input logic [7:0] n,
                             input logic [31:0] b, input logic r);
        logic ok;
        int   w;
        in_valid = 1'b1;
        in_sum   = s;
        num_ch   = n;
        bias     = b;
        relu_en  = r;
        ok = 1'b0;
        w  = 0;
        while (!ok && w < 300) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            w++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready got 0, expected 1 within 300 cycles");
        end
    endtask

    task automatic wait_out_valid();
        int w;
        w = 0;
        while (w < 50) begin
            @(negedge clk);
            if (out_valid) break;
            w++;
        end
        chk("out_valid_wait", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("drain", sb.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{3, 8'd3, 32'h4000, 1'b0,
                    {38'd0, -38'sh8000, 38'sh20000, 38'sh10000}, 32'h0002_C000};
        vecs[1] = '{2, 8'd2, 32'h0, 1'b1,
                    {38'd0, 38'd0, 38'sh10000, -38'sh30000}, 32'h0000_0000};
        vecs[2] = '{2, 8'd2, 32'h0, 1'b0,
                    {38'd0, 38'd0, 38'sh10000, -38'sh30000}, 32'hFFFE_0000};
        vecs[3] = '{1, 8'd0, 32'h0, 1'b0,
                    {38'd0, 38'd0, 38'd0, 38'sh10000}, 32'h0001_0000};
        vecs[4] = '{1, 8'd1, 32'h8000, 1'b1,
                    {38'd0, 38'd0, 38'd0, -38'sh10000}, 32'h0000_0000};
        vecs[5] = '{4, 8'd4, 32'hFFFF_0000, 1'b0,
                    {38'sh10000, 38'sh10000, 38'sh10000, 38'sh10000}, 32'h0003_0000};
        vecs[6] = '{2, 8'd2, 32'h0001_0000, 1'b0,
                    {38'd0, 38'd0, 38'sh3FFF8000, 38'sh3FFF8000}, 32'h7FFF_FFFF};
        vecs[7] = '{2, 8'd2, 32'h0000_FFFF, 1'b0,
                    {38'd0, 38'd0, 38'sh3FFF8000, 38'sh3FFF8000}, 32'h7FFF_FFFF};
        vecs[8] = '{2, 8'd2, 32'hFFFF_FFFF, 1'b0,
                    {38'd0, 38'd0, -38'sh40000000, -38'sh40000000}, 32'h8000_0000};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sum    = '0;
        num_ch    = '0;
        bias      = '0;
        relu_en   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_data", out_data, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            sb.push_back(vecs[i].exp);
            for (int k = 0; k < vecs[i].nbeats; k++)
                send_beat(vecs[i].sums[k], vecs[i].nch, vecs[i].b, vecs[i].relu);
        end
        wait_drain();

        // Exact negative boundary without saturation.
        sb.push_back(32'h8000_0000);
        send_beat(-38'sh40000000, 8'd2, 32'h0, 1'b0);
        send_beat(-38'sh40000000, 8'd2, 32'h0, 1'b0);

        // Config changes after the first beat must be ignored.
        sb.push_back(32'hFFFD_4000);
        send_beat(38'sh10000, 8'd3, 32'h4000, 1'b0);
        send_beat(38'sh10000, 8'd1, 32'h7FFF, 1'b1);
        send_beat(-38'sh50000, 8'd9, 32'h0, 1'b1);
        wait_drain();

        // Back-to-back throughput: num_ch + 2 cycles per pixel.
        hs_cyc.delete();
        sb.push_back(32'h0003_0000);
        sb.push_back(32'h0003_0000);
        for (int g = 0; g < 2; g++)
            for (int k = 0; k < 3; k++)
                send_beat(38'sh10000, 8'd3, 32'h0, 1'b0);
        wait_drain();
        if (hs_cyc.size() >= 2)
            chk("throughput", hs_cyc[1] - hs_cyc[0], 32'd5);
        else
            chk("throughput_count", hs_cyc.size(), 32'd2);

        // Output backpressure with upstream holding a beat.
        out_ready = 1'b0;
        sb.push_back(32'h0002_0000);
        send_beat(38'sh10000, 8'd2, 32'h0, 1'b0);
        send_beat(38'sh10000, 8'd2, 32'h0, 1'b0);
        wait_out_valid();
        in_valid = 1'b1;
        in_sum   = 38'sh30000;
        num_ch   = 8'd2;
        bias     = 32'h0;
        relu_en  = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_out_data", out_data, 32'h0002_0000);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        sb.push_back(32'h0004_0000);
        send_beat(38'sh30000, 8'd2, 32'h0, 1'b0);
        send_beat(38'sh10000, 8'd2, 32'h0, 1'b0);
        wait_drain();

        // Reset mid-group discards the partial sum.
        send_beat(38'sh10000, 8'd4, 32'h0, 1'b0);
        send_beat(38'sh10000, 8'd4, 32'h0, 1'b0);
        pulse_reset();
        sb.push_back(32'h0004_0000);
        for (int k = 0; k < 4; k++)
            send_beat(38'sh10000, 8'd4, 32'h0, 1'b0);
        wait_drain();

        // Reset while a result is pending in OUT drops it.
        out_ready = 1'b0;
        send_beat(38'sh50000, 8'd1, 32'h0, 1'b0);
        wait_out_valid();
        chk("pending_out_data", out_data, 32'h0005_0000);
        pulse_reset();
        out_ready = 1'b1;
        sb.push_back(32'h0001_0000);
        send_beat(38'sh10000, 8'd1, 32'h0, 1'b0);
        wait_drain();

        // Full-scale inputs across 255 channels saturate without wrapping.
        sb.push_back(32'h7FFF_FFFF);
        for (int k = 0; k < 255; k++)
            send_beat(38'h1F_FFFF_FFFF, 8'd255, 32'h0, 1'b0);
        sb.push_back(32'h8000_0000);
        for (int k = 0; k < 255; k++)
            send_beat(38'h20_0000_0000, 8'd255, 32'h0, 1'b0);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
